// File: rtl/chimera_pkg.sv
// chimera_pkg: shared state type, default constants and width helper for the cluster clock-gate sequencer
package chimera_pkg;
  typedef enum logic [1:0] {RUN, ISOLATE, GATED, WAKE} gate_state_e;
  localparam int ChimeraMaxOutstanding = 16;
  localparam int ChimeraDrainTimeout = 1024;
  localparam int ChimeraSettleCycles = 4;
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction
endpackage

// File: rtl/chimera_clu_gate_fsm.sv
// chimera_clu_gate_fsm: isolate, drain, gate and wake sequencer for one cluster clock domain
module chimera_clu_gate_fsm
  import chimera_pkg::*;
#(
  parameter int MaxOutstanding = ChimeraMaxOutstanding,
  parameter int DrainTimeout = ChimeraDrainTimeout,
  parameter int SettleCycles = ChimeraSettleCycles
) (
  input  logic clk,
  input  logic rst,
  input  logic gate_req,
  input  logic req_hs,
  input  logic rsp_hs,
  output logic clk_en,
  output logic isolate,
  output logic gated,
  output logic timeout,
  output logic cnt_err
);
  localparam int CW = cnt_width(MaxOutstanding);
  localparam int TW = cnt_width(DrainTimeout > SettleCycles ? DrainTimeout : SettleCycles);
  localparam logic [CW-1:0] CntMax = CW'(MaxOutstanding);
  localparam logic [TW-1:0] DrainLast = TW'(DrainTimeout - 1);
  localparam logic [TW-1:0] SettleLast = TW'(SettleCycles - 1);

  gate_state_e state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [TW-1:0] timer, timer_d;
  logic inc, dec, drained;
  logic cnt_err_d, timeout_d, clk_en_d, isolate_d, gated_d;

  assign inc = req_hs & ~rsp_hs;
  assign dec = rsp_hs & ~req_hs;
  assign drained = (cnt == '0) && !req_hs && !rsp_hs;
  assign cnt_d = inc ? ((cnt == CntMax) ? cnt : cnt + 1'b1) : dec ? ((cnt == '0) ? cnt : cnt - 1'b1) : cnt;
  assign cnt_err_d = cnt_err | (inc && cnt == CntMax) | (dec && cnt == '0);
  // Timer only runs in ISOLATE/WAKE and sits at zero elsewhere, so every entry starts from 0
  assign timer_d = (state == ISOLATE || state == WAKE) ? timer + 1'b1 : '0;
  // Leaving ISOLATE for RUN while still requested can only be the drain timeout
  assign timeout_d = (state == RUN && gate_req) ? 1'b0 :
                     (state == ISOLATE && state_d == RUN && gate_req) ? 1'b1 : timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt <= '0;
      timer <= '0;
      timeout <= 1'b0;
      cnt_err <= 1'b0;
      clk_en <= 1'b1;
      isolate <= 1'b0;
      gated <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      timer <= timer_d;
      timeout <= timeout_d;
      cnt_err <= cnt_err_d;
      clk_en <= clk_en_d;
      isolate <= isolate_d;
      gated <= gated_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      RUN:     state_d = gate_req ? ISOLATE : RUN;
      ISOLATE: state_d = !gate_req ? RUN : drained ? GATED : (timer == DrainLast) ? RUN : ISOLATE;
      GATED:   state_d = gate_req ? GATED : WAKE;
      WAKE:    state_d = (timer == SettleLast) ? RUN : WAKE;
      default: state_d = RUN;
    endcase
  end

  // Outputs are decoded from the next state and registered alongside it
  always_comb begin
    clk_en_d = state_d != GATED;
    isolate_d = state_d != RUN;
    gated_d = state_d == GATED;
  end

  if (SettleCycles < 1) begin : g_bad_settle
    $error("SettleCycles must be at least 1");
  end

  assert property (@(posedge clk) disable iff (rst) !(req_hs && isolate && state != ISOLATE))
    else $error("request handshake while isolated outside ISOLATE");
endmodule

// File: rtl/chimera_clu_gate_ctrl.sv
// chimera_clu_gate_ctrl: independent clock-gate sequencers, one per cluster
module chimera_clu_gate_ctrl
  import chimera_pkg::*;
#(
  parameter int NumClusters = 5,
  parameter int MaxOutstanding = ChimeraMaxOutstanding,
  parameter int DrainTimeout = ChimeraDrainTimeout,
  parameter int SettleCycles = ChimeraSettleCycles
) (
  input  logic                   soc_clk_i,
  input  logic                   rst_i,
  input  logic [NumClusters-1:0] gate_req_i,
  input  logic [NumClusters-1:0] req_hs_i,
  input  logic [NumClusters-1:0] rsp_hs_i,
  output logic [NumClusters-1:0] clk_en_o,
  output logic [NumClusters-1:0] isolate_o,
  output logic [NumClusters-1:0] gated_o,
  output logic [NumClusters-1:0] timeout_o,
  output logic [NumClusters-1:0] cnt_err_o
);
  for (genvar i = 0; i < NumClusters; i++) begin : g_clu
    chimera_clu_gate_fsm #(
      .MaxOutstanding(MaxOutstanding),
      .DrainTimeout(DrainTimeout),
      .SettleCycles(SettleCycles)
    ) u_fsm (
      .clk(soc_clk_i),
      .rst(rst_i),
      .gate_req(gate_req_i[i]),
      .req_hs(req_hs_i[i]),
      .rsp_hs(rsp_hs_i[i]),
      .clk_en(clk_en_o[i]),
      .isolate(isolate_o[i]),
      .gated(gated_o[i]),
      .timeout(timeout_o[i]),
      .cnt_err(cnt_err_o[i])
    );
  end
endmodule

// File: tb/tb_chimera_clu_gate_ctrl.sv
// tb_chimera_clu_gate_ctrl: directed stimulus with expected outputs tagged by the cycle they must appear in
module tb_chimera_clu_gate_ctrl;
  localparam int NC = 5;
  localparam int CE = 0, ISO = 1, GT = 2, TMO = 3, ERR = 4;

  typedef struct packed {
    int cyc;
    int clu;
    int sig;
    logic val;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [NC-1:0] gate_req, req_hs, rsp_hs;
  logic [NC-1:0] clk_en, isolate, gated, timeout, cnt_err;
  exp_t sb[$];
  int cyc = 0;
  int applied = 0;
  int miscompares = 0;

  chimera_clu_gate_ctrl #(
    .NumClusters(NC),
    .MaxOutstanding(16),
    .DrainTimeout(1024),
    .SettleCycles(4)
  ) dut (
    .soc_clk_i(clk),
    .rst_i(rst),
    .gate_req_i(gate_req),
    .req_hs_i(req_hs),
    .rsp_hs_i(rsp_hs),
    .clk_en_o(clk_en),
    .isolate_o(isolate),
    .gated_o(gated),
    .timeout_o(timeout),
    .cnt_err_o(cnt_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic get_sig(int c, int s);
    return (s == CE) ? clk_en[c] : (s == ISO) ? isolate[c] : (s == GT) ? gated[c] :
           (s == TMO) ? timeout[c] : cnt_err[c];
  endfunction

  function automatic string sig_name(int s);
    return (s == CE) ? "clk_en" : (s == ISO) ? "isolate" : (s == GT) ? "gated" :
           (s == TMO) ? "timeout" : "cnt_err";
  endfunction

  task automatic step(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(int dc, int c, int s, logic v);
    exp_t e;
    e.cyc = cyc + dc;
    e.clu = c;
    e.sig = s;
    e.val = v;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    logic a;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        a = get_sig(sb[i].clu, sb[i].sig);
        applied++;
        if (a !== sb[i].val) begin
          miscompares++;
          $display("FAIL %s[%0d] cycle %0d: got %b, expected %b", sig_name(sb[i].sig), sb[i].clu, cyc, a, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    gate_req = '0;
    req_hs = '0;
    rsp_hs = '0;
    step(3);
    rst = 1'b0;
    applied++;
    if (clk_en !== '1 || isolate !== '0 || gated !== '0 || timeout !== '0 || cnt_err !== '0) begin
      miscompares++;
      $display("FAIL reset values: clk_en %b isolate %b gated %b timeout %b cnt_err %b", clk_en, isolate, gated, timeout, cnt_err);
    end
    for (int c = 0; c < NC; c++) begin
      chk(0, c, CE, 1'b1);
      chk(0, c, ISO, 1'b0);
      chk(0, c, GT, 1'b0);
      chk(0, c, TMO, 1'b0);
      chk(0, c, ERR, 1'b0);
    end
    step();
    gate_req[0] = 1'b1;
    chk(1, 0, ISO, 1'b1);
    chk(1, 0, CE, 1'b1);
    chk(2, 0, CE, 1'b0);
    chk(2, 0, GT, 1'b1);
    step(3);
    chk(0, 0, CE, 1'b0);
    gate_req[0] = 1'b0;
    chk(1, 0, CE, 1'b1);
    chk(1, 0, GT, 1'b0);
    chk(4, 0, ISO, 1'b1);
    chk(5, 0, ISO, 1'b0);
    step(6);
    req_hs[1] = 1'b1;
    step(3);
    req_hs[1] = 1'b0;
    gate_req[1] = 1'b1;
    chk(1, 1, ISO, 1'b1);
    step(2);
    for (int k = 0; k < 3; k++) begin
      rsp_hs[1] = 1'b1;
      chk(0, 1, CE, 1'b1);
      step();
      rsp_hs[1] = 1'b0;
      if (k < 2) step(9);
    end
    chk(0, 1, CE, 1'b1);
    chk(1, 1, CE, 1'b0);
    chk(1, 1, GT, 1'b1);
    step(2);
    gate_req[1] = 1'b0;
    step(7);
    req_hs[2] = 1'b1;
    step();
    req_hs[2] = 1'b0;
    gate_req[2] = 1'b1;
    chk(1024, 2, ISO, 1'b1);
    chk(1024, 2, TMO, 1'b0);
    chk(1025, 2, ISO, 1'b0);
    chk(1025, 2, TMO, 1'b1);
    chk(1025, 2, CE, 1'b1);
    chk(1026, 2, TMO, 1'b0);
    chk(1026, 2, ISO, 1'b1);
    step(1026);
    gate_req[2] = 1'b0;
    chk(1, 2, ISO, 1'b0);
    step();
    rsp_hs[2] = 1'b1;
    step();
    rsp_hs[2] = 1'b0;
    chk(1, 2, ERR, 1'b0);
    step(2);
    req_hs[3] = 1'b1;
    step(2);
    req_hs[3] = 1'b0;
    gate_req[3] = 1'b1;
    for (int k = 1; k <= 4; k++) chk(k, 3, CE, 1'b1);
    chk(1, 3, ISO, 1'b1);
    chk(3, 3, ISO, 1'b1);
    chk(4, 3, ISO, 1'b0);
    chk(4, 3, TMO, 1'b0);
    step(3);
    gate_req[3] = 1'b0;
    step(2);
    rsp_hs[3] = 1'b1;
    step(2);
    rsp_hs[3] = 1'b0;
    chk(1, 3, ERR, 1'b0);
    step();
    req_hs[4] = 1'b1;
    rsp_hs[4] = 1'b1;
    step(100);
    req_hs[4] = 1'b0;
    rsp_hs[4] = 1'b0;
    chk(1, 4, ERR, 1'b0);
    gate_req[4] = 1'b1;
    chk(2, 4, CE, 1'b0);
    step(3);
    gate_req[4] = 1'b0;
    step(6);
    rsp_hs[4] = 1'b1;
    chk(0, 4, ERR, 1'b0);
    chk(1, 4, ERR, 1'b1);
    step();
    rsp_hs[4] = 1'b0;
    req_hs[0] = 1'b1;
    chk(16, 0, ERR, 1'b0);
    chk(17, 0, ERR, 1'b1);
    step(17);
    req_hs[0] = 1'b0;
    step();
    gate_req[2] = 1'b1;
    step(3);
    chk(0, 2, CE, 1'b0);
    chk(0, 2, GT, 1'b1);
    for (int c = 0; c < NC; c++) begin
      if (c != 2) begin
        chk(0, c, CE, 1'b1);
        chk(0, c, ISO, 1'b0);
      end
    end
    chk(0, 0, ERR, 1'b1);
    chk(0, 4, ERR, 1'b1);
    step();
    rst = 1'b1;
    gate_req[2] = 1'b0;
    #1;
    applied++;
    if (clk_en !== '1 || isolate !== '0) begin
      miscompares++;
      $display("FAIL async reset: clk_en %b isolate %b", clk_en, isolate);
    end
    chk(0, 2, CE, 1'b1);
    chk(0, 2, ISO, 1'b0);
    chk(0, 2, GT, 1'b0);
    chk(0, 0, ERR, 1'b0);
    step();
    rst = 1'b0;
    chk(1, 2, CE, 1'b1);
    chk(1, 2, ISO, 1'b0);
    chk(1, 4, ERR, 1'b0);
    step(3);
    foreach (sb[i]) begin
      miscompares++;
      $display("FAIL %s[%0d] expected at cycle %0d never checked", sig_name(sb[i].sig), sb[i].clu, sb[i].cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    if (miscompares == 0) $display("PASS");
    else $display("FAIL");
    $finish;
  end
endmodule
